// File: rtl/rv_ifu_fetch.sv
// RV32 instruction fetch stage: owns the PC and fetches one word at a time into a decode-facing message register.
// Optional misaligned-fetch trap enabled by defining IFU_MISALIGN_CHK_EN (adds output fetch_misalign).
module rv_ifu_fetch #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned      IF_ID_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WIDTH-1:0]       imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [WIDTH-1:0]       imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   IF_ID_valid,
    input  logic                   IF_ID_ready,
    output logic [IF_ID_WIDTH-1:0] IF_ID_message
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                   fetch_misalign
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

    state_t                 state_r;
    state_t                 state_s;
    logic [WIDTH-1:0]       pc_r;
    logic [WIDTH-1:0]       pc_s;
    logic [WIDTH-1:0]       pc_inc_s;
    logic                   valid_r;
    logic                   valid_s;
    logic [IF_ID_WIDTH-1:0] msg_r;
    logic [IF_ID_WIDTH-1:0] msg_s;
    logic                   req_valid_r;
    logic                   req_valid_s;
    logic                   req_fire_s;
    logic                   hs_s;
    logic                   pc_fault_s;
`ifdef IFU_MISALIGN_CHK_EN
    logic                   misalign_r;
    logic                   misalign_s;
`endif

    // Next state, next PC and next output-register values; redirect overrides everything else
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        valid_s    = valid_r;
        msg_s      = msg_r;
        pc_inc_s   = pc_r + PC_STEP;
        req_fire_s = req_valid_r & imem_req_ready;
        hs_s       = valid_r & IF_ID_ready;
`ifdef IFU_MISALIGN_CHK_EN
        misalign_s = misalign_r;
        pc_fault_s = (pc_r[1:0] != 2'b00);
`else
        pc_fault_s = 1'b0;
`endif

        if (redirect_valid) begin
            pc_s    = redirect_pc;
            valid_s = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_s = 1'b0;
`endif
            case (state_r)
                ST_IDLE: state_s = ST_REQ;
                ST_REQ: begin
                    // An accepted request still owes us a response that must be swallowed
                    if (req_fire_s) begin
                        state_s = ST_DROP;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                ST_HOLD: state_s = ST_REQ;
                ST_DROP: begin
                    // A stale response arriving with the redirect retires the outstanding request
                    if (imem_rsp_valid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_REQ;
                ST_REQ: begin
                    if (pc_fault_s) begin
                        state_s = ST_HOLD;
                        msg_s   = {pc_r, {WIDTH{1'b0}}};
                        valid_s = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
                        misalign_s = 1'b1;
`endif
                    end else if (req_fire_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_s = ST_HOLD;
                        msg_s   = {pc_r, imem_rsp_data};
                        valid_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (hs_s) begin
                        state_s = ST_REQ;
                        pc_s    = pc_inc_s;
                        valid_s = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
                        misalign_s = 1'b0;
`endif
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    pc_s    = RESET_PC;
                    valid_s = 1'b0;
                end
            endcase
        end

        // Request line is registered: it reflects the state being entered
`ifdef IFU_MISALIGN_CHK_EN
        req_valid_s = (state_s == ST_REQ) && (pc_s[1:0] == 2'b00);
`else
        req_valid_s = (state_s == ST_REQ);
`endif
    end

    // State, PC and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            valid_r     <= 1'b0;
            msg_r       <= {IF_ID_WIDTH{1'b0}};
            req_valid_r <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            valid_r     <= valid_s;
            msg_r       <= msg_s;
            req_valid_r <= req_valid_s;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_r  <= misalign_s;
`endif
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign IF_ID_valid    = valid_r;
    assign IF_ID_message  = msg_r;
`ifdef IFU_MISALIGN_CHK_EN
    assign fetch_misalign = misalign_r;
`endif

endmodule
